// File: rtl/cache_block_transfer_controller_if.sv
// Bus bundle between the miss engine, the cache controller/way and the memory bus.
// The master modport is the controller side; slave is the cache/memory environment.
interface cache_block_transfer_controller_if #(
    parameter int tagbits   = 14,
    parameter int blocksize = 4
);
    logic                      MissReq;
    logic [31:0]               MissAddr;
    logic                      VictimDirty;
    logic [tagbits-1:0]        VictimTag;
    logic [blocksize*32-1:0]   VictimBlock;
    logic                      WayWE;
    logic [31:0]               WayA;
    logic [31:0]               WayWD;
    logic [3:0]                WayByteMask;
    logic                      WayDirtyIn;
    logic                      WayVin;
    logic                      MemReq;
    logic                      MemWrite;
    logic [31:0]               MemAddr;
    logic [31:0]               MemWD;
    logic                      MemAck;
    logic [31:0]               MemRD;
    logic                      Busy;
    logic                      Done;

    modport master (
        input  MissReq, MissAddr, VictimDirty, VictimTag, VictimBlock, MemAck, MemRD,
        output WayWE, WayA, WayWD, WayByteMask, WayDirtyIn, WayVin,
               MemReq, MemWrite, MemAddr, MemWD, Busy, Done
    );

    modport slave (
        output MissReq, MissAddr, VictimDirty, VictimTag, VictimBlock, MemAck, MemRD,
        input  WayWE, WayA, WayWD, WayByteMask, WayDirtyIn, WayVin,
               MemReq, MemWrite, MemAddr, MemWD, Busy, Done
    );
endinterface

// File: rtl/cache_block_transfer_controller.sv
// Miss engine for one writeback way: writes back a dirty victim block word by word,
// then fills the new block from memory, one way write per acknowledged memory beat.
module cache_block_transfer_controller #(
    parameter int tagbits   = 14,
    parameter int blocksize = 4
) (
    input  logic clk,
    input  logic reset_n,
    cache_block_transfer_controller_if.master bus
);
    localparam int cntbits  = $clog2(blocksize);
    localparam int offbits  = cntbits + 2;
    localparam int setbits  = 32 - tagbits - offbits;
    localparam int linebits = 32 - offbits;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                    state, state_next;
    logic [cntbits-1:0]        cnt, cnt_next;
    logic [linebits-1:0]       line_addr;
    logic [tagbits-1:0]        victim_tag;
    logic [blocksize*32-1:0]   victim_block;
    logic                      accept;
    logic                      last_word;
    logic                      unused_offset;

    assign accept        = (state == IDLE) && bus.MissReq;
    assign last_word     = (cnt == cntbits'(blocksize - 1));
    // Word/byte offset of the miss address is regenerated from the beat counter.
    assign unused_offset = ^bus.MissAddr[offbits-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Victim and miss context only matter while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_addr    <= bus.MissAddr[31:offbits];
            victim_tag   <= bus.VictimTag;
            victim_block <= bus.VictimBlock;
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        bus.MemReq      = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemAddr     = '0;
        bus.MemWD       = '0;
        bus.WayWE       = 1'b0;
        bus.WayA        = '0;
        bus.WayWD       = '0;
        bus.WayVin      = 1'b0;
        bus.WayDirtyIn  = 1'b0;
        bus.Busy        = 1'b1;
        bus.Done        = 1'b0;

        case (state)
            IDLE: begin
                bus.Busy = 1'b0;
                if (bus.MissReq) begin
                    cnt_next   = '0;
                    state_next = bus.VictimDirty ? WB : FILL;
                end
            end
            WB: begin
                bus.MemReq   = 1'b1;
                bus.MemWrite = 1'b1;
                bus.MemAddr  = {victim_tag, line_addr[setbits-1:0], cnt, 2'b00};
                bus.MemWD    = victim_block[32*cnt +: 32];
                if (bus.MemAck) begin
                    cnt_next = cnt + 1'b1;
                    if (last_word) state_next = FILL;
                end
            end
            FILL: begin
                bus.MemReq  = 1'b1;
                bus.MemAddr = {line_addr, cnt, 2'b00};
                if (bus.MemAck) begin
                    // The line becomes valid only with its final word.
                    bus.WayWE  = 1'b1;
                    bus.WayA   = {line_addr, cnt, 2'b00};
                    bus.WayWD  = bus.MemRD;
                    bus.WayVin = last_word;
                    cnt_next   = cnt + 1'b1;
                    if (last_word) state_next = DONE;
                end
            end
            DONE: begin
                bus.Done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        bus.WayByteMask = bus.WayWE ? 4'b1111 : 4'b0000;
    end
endmodule

// File: tb/tb_cache_block_transfer_controller.sv
// Randomized/directed bench for cache_block_transfer_controller with a beat-list
// reference model built from the block address arithmetic.
module tb_cache_block_transfer_controller;
    localparam int TB = 14;
    localparam int BS = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    cache_block_transfer_controller_if #(.tagbits(TB), .blocksize(BS)) bus ();

    cache_block_transfer_controller #(.tagbits(TB), .blocksize(BS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(bus.Busy), 32'd0);
        check({tag, "_memreq"}, 32'(bus.MemReq), 32'd0);
        check({tag, "_waywe"}, 32'(bus.WayWE), 32'd0);
        check({tag, "_done"}, 32'(bus.Done), 32'd0);
    endtask

    // One miss: model builds the expected beat list, bench plays the memory.
    task automatic run_miss(input logic [31:0] addr, input logic dirty, input logic [TB-1:0] tag,
                            input logic [BS*32-1:0] blk, input logic [BS*32-1:0] fill,
                            input int dmin, input int dmax, input bit poke, input int abort_after);
        logic [31:0] exp_addr[$];
        logic        exp_wr[$];
        logic [31:0] exp_wd[$];
        int cycles, waitc, delay, fidx, wayw, vins;
        bit done_seen;
        logic wr;

        for (int i = 0; i < BS; i++) begin
            if (dirty) begin
                exp_addr.push_back({tag, 18'd0} | (addr & 32'h0003_FFF0) | 32'(i * 4));
                exp_wr.push_back(1'b1);
                exp_wd.push_back(blk[32*i +: 32]);
            end
        end
        for (int i = 0; i < BS; i++) begin
            exp_addr.push_back((addr & 32'hFFFF_FFF0) | 32'(i * 4));
            exp_wr.push_back(1'b0);
            exp_wd.push_back(fill[32*i +: 32]);
        end

        @(negedge clk);
        bus.MemAck = 1'b0;
        bus.MissAddr = addr;
        bus.VictimDirty = dirty;
        bus.VictimTag = tag;
        bus.VictimBlock = blk;
        bus.MissReq = 1'b1;
        #1;
        check_quiet("accept");
        @(posedge clk);
        @(negedge clk);
        bus.MissReq = 1'b0;
        bus.MissAddr = $urandom;
        bus.VictimTag = TB'($urandom);
        bus.VictimBlock = {$urandom, $urandom, $urandom, $urandom};

        cycles = 0; waitc = 0; fidx = 0; wayw = 0; vins = 0; done_seen = 0;
        delay = int'($urandom_range(dmax, dmin));
        while (cycles < 400) begin
            #1;
            cycles++;
            if (bus.Done) begin
                done_seen = 1;
                break;
            end
            check("busy", 32'(bus.Busy), 32'd1);
            bus.MissReq = poke && (cycles == 2);
            if (exp_addr.size() == 0) begin
                check("memreq_extra", 32'(bus.MemReq), 32'd0);
            end else begin
                wr = exp_wr[0];
                check("memreq", 32'(bus.MemReq), 32'd1);
                check("memwrite", 32'(bus.MemWrite), 32'(wr));
                check("memaddr", bus.MemAddr, exp_addr[0]);
                if (wr) check("memwd", bus.MemWD, exp_wd[0]);
                if (waitc >= delay) begin
                    bus.MemAck = 1'b1;
                    bus.MemRD = wr ? $urandom : exp_wd[0];
                    #1;
                    check("waywe", 32'(bus.WayWE), 32'(!wr));
                    check("waydirty", 32'(bus.WayDirtyIn), 32'd0);
                    if (!wr) begin
                        check("waya", bus.WayA, exp_addr[0]);
                        check("waywd", bus.WayWD, exp_wd[0]);
                        check("waymask", 32'(bus.WayByteMask), 32'hF);
                        check("wayvin", 32'(bus.WayVin), 32'(fidx == BS - 1));
                        wayw += int'(bus.WayWE);
                        vins += int'(bus.WayVin);
                        fidx++;
                    end
                    void'(exp_addr.pop_front());
                    void'(exp_wr.pop_front());
                    void'(exp_wd.pop_front());
                    waitc = 0;
                    delay = int'($urandom_range(dmax, dmin));
                end else begin
                    waitc++;
                    check("waywe_wait", 32'(bus.WayWE), 32'd0);
                    check("wayvin_wait", 32'(bus.WayVin), 32'd0);
                end
            end
            @(posedge clk);
            @(negedge clk);
            bus.MemAck = 1'b0;
            if (abort_after > 0 && fidx == abort_after) begin
                reset_n = 1'b0;
                #1;
                check_quiet("abort");
                check("abort_vin_seen", 32'(vins), 32'd0);
                check("abort_vin", 32'(bus.WayVin), 32'd0);
                @(posedge clk);
                @(negedge clk);
                reset_n = 1'b1;
                @(posedge clk);
                @(negedge clk);
                #1;
                check_quiet("after_abort");
                return;
            end
        end

        check("done_timeout", 32'(done_seen), 32'd1);
        check("beats_left", 32'(exp_addr.size()), 32'd0);
        check("waywe_count", 32'(wayw), 32'(BS));
        check("vin_count", 32'(vins), 32'd1);
        if (dmax == 0) check("latency", 32'(cycles), 32'(dirty ? 2 * BS + 1 : BS + 1));
        check("done_busy", 32'(bus.Busy), 32'd1);
        bus.MissReq = poke;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_quiet("post_done");
        bus.MissReq = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_quiet("no_second");
    endtask

    initial begin
        bus.MissReq = 1'b0;
        bus.MissAddr = '0;
        bus.VictimDirty = 1'b0;
        bus.VictimTag = '0;
        bus.VictimBlock = '0;
        bus.MemAck = 1'b0;
        bus.MemRD = '0;
        #1;
        check_quiet("reset");
        check("reset_memaddr", bus.MemAddr, 32'd0);
        check("reset_vin", 32'(bus.WayVin), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Clean miss, ack every cycle.
        run_miss(32'h0000_1234, 1'b0, 14'h0, '0,
                 128'h0000_00A3_0000_00A2_0000_00A1_0000_00A0, 0, 0, 1'b0, 0);
        // Dirty miss with all-ones victim tag.
        run_miss(32'h0000_1230, 1'b1, 14'h3FFF,
                 128'h0000_00D3_0000_00D2_0000_00D1_0000_00D0,
                 128'h0000_00A3_0000_00A2_0000_00A1_0000_00A0, 0, 0, 1'b0, 0);
        // Ack delayed three cycles per beat.
        run_miss(32'h0000_5678, 1'b0, 14'h0, '0,
                 {$urandom, $urandom, $urandom, $urandom}, 3, 3, 1'b0, 0);
        // MissReq pokes during WB and DONE.
        run_miss(32'hABCD_0040, 1'b1, 14'h1555,
                 {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1'b1, 0);
        // Reset after the second fill beat.
        run_miss(32'h0000_9990, 1'b0, 14'h0, '0,
                 {$urandom, $urandom, $urandom, $urandom}, 0, 1, 1'b0, 2);

        // Spurious acks while idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.MemAck = 1'b1;
            bus.MemRD = $urandom;
            #1;
            check_quiet("spurious");
        end
        @(negedge clk);
        bus.MemAck = 1'b0;
        #1;
        check_quiet("spurious_after");

        // Randomized misses.
        for (int n = 0; n < 8; n++) begin
            run_miss($urandom, 1'($urandom), TB'($urandom),
                     {$urandom, $urandom, $urandom, $urandom},
                     {$urandom, $urandom, $urandom, $urandom},
                     0, int'($urandom_range(2, 0)), 1'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
